dds_div_dac: RTL and testbench



---
 rtl/dds_div_dac.sv | 136 +++++++++++++
 tb/tb_dds_div_dac.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dds_div_dac.sv
// Audio back-end: per-voice quarter-wave sine lookup, free-running 33-cycle divider, PWM DAC.
// Optional macro DAC_SYNC_UPDATE_EN: latch the PWM threshold only at the period wrap (glitch-free).

module dds_sin_lane (
    input  logic [7:0] theta,
    output logic [7:0] amp
);
    localparam logic [6:0] SIN_Q [0:64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    logic [6:0] idx;
    logic [6:0] mag;

    // Odd quadrants mirror the index, the lower half-wave negates the magnitude.
    assign idx = theta[6] ? (7'd64 - {1'b0, theta[5:0]}) : {1'b0, theta[5:0]};
    assign mag = SIN_Q[idx];
    assign amp = theta[7] ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
endmodule

module dds_div_dac #(
    parameter int CLK_FREQ    = 120_000_000,
    parameter int PWM_FREQ    = 500_000,
    parameter int PLAYER_NUM  = 3,
    parameter int THETA_WIDTH = 8,
    parameter int AM_WIDTH    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [THETA_WIDTH*PLAYER_NUM-1:0] dds_theta,
    output logic [AM_WIDTH*PLAYER_NUM-1:0]    dds_am,
    input  logic signed [31:0]                am_sum,
    input  logic [7:0]                        den,
    output logic [7:0]                        am,
    output logic                              wave
);
    localparam int          PERIOD   = CLK_FREQ / PWM_FREQ;
    localparam logic [15:0] PERIOD_W = 16'(PERIOD);

    for (genvar g = 0; g < PLAYER_NUM; g++) begin : g_voice
        dds_sin_lane u_lane (
            .theta (dds_theta[THETA_WIDTH*g +: THETA_WIDTH]),
            .amp   (dds_am[AM_WIDTH*g +: AM_WIDTH])
        );
    end

    typedef enum logic {LOAD, RUN} div_state_t;

    div_state_t  state, state_nxt;
    logic [31:0] num_q, quo_q, quo_nxt;
    logic [7:0]  den_q, rem_q, rem_nxt, result;
    logic [4:0]  idx_q;
    logic [8:0]  trial;
    logic        ge;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = RUN;
            RUN:     if (idx_q == 5'd0) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // One restoring step; the remainder stays below den so 8 bits hold it.
    always_comb begin
        trial   = {rem_q, num_q[idx_q]};
        ge      = trial >= {1'b0, den_q};
        rem_nxt = ge ? 8'(trial - {1'b0, den_q}) : trial[7:0];
        quo_nxt = quo_q;
        quo_nxt[idx_q] = ge;
        if (den_q == 8'd0)        result = 8'd255;
        else if (num_q[31])       result = 8'd0;
        else if (|quo_nxt[31:8])  result = 8'd255;
        else                      result = quo_nxt[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            am    <= 8'd128;
            num_q <= '0;
            den_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            idx_q <= 5'd31;
        end else if (state == LOAD) begin
            num_q <= am_sum;
            den_q <= den;
            rem_q <= '0;
            quo_q <= '0;
            idx_q <= 5'd31;
        end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            idx_q <= idx_q - 5'd1;
            if (idx_q == 5'd0) am <= result;
        end
    end

    logic [15:0] cnt, thr, thr_calc;
    logic [23:0] prod;
    logic        wrap;

    assign prod     = {16'd0, am} * {8'd0, PERIOD_W};
    assign thr_calc = prod[23:8];
    assign wrap     = (cnt == PERIOD_W - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            thr  <= '0;
            wave <= 1'b0;
        end else begin
            cnt  <= wrap ? 16'd0 : cnt + 16'd1;
            wave <= (cnt < thr);
`ifdef DAC_SYNC_UPDATE_EN
            if (wrap) thr <= thr_calc;
`else
            thr <= thr_calc;
`endif
        end
    end
endmodule

// File: tb/tb_dds_div_dac.sv
// Directed bench for dds_div_dac: sine table points, divider result rules, PWM duty, reset and update mode.
module tb_dds_div_dac;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [23:0]        dds_theta = '0;
    logic [23:0]        dds_am;
    logic signed [31:0] am_sum = 32'sd384;
    logic [7:0]         den = 8'd3;
    logic [7:0]         am;
    logic               wave;

    int n_vec = 0;
    int n_err = 0;

    dds_div_dac dut (
        .clk(clk), .rst(rst), .dds_theta(dds_theta), .dds_am(dds_am),
        .am_sum(am_sum), .den(den), .am(am), .wave(wave)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] th; logic [7:0] exp_am; } sin_vec_t;
    typedef struct { int sum; logic [7:0] d; logic [7:0] exp_am; } div_vec_t;
    typedef struct { int sum; logic [7:0] d; int exp_high; } pwm_vec_t;

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    sin_vec_t sv[10];
    div_vec_t dv[9];
    pwm_vec_t pv[4];

    initial begin
        int h, h1, h2, h3;
        sv = '{'{8'd0, 8'd0}, '{8'd32, 8'd90}, '{8'd64, 8'd127}, '{8'd128, 8'd0},
               '{8'd192, 8'h81}, '{8'd255, 8'hFD}, '{8'd1, 8'd3}, '{8'd96, 8'd90},
               '{8'd160, 8'hA6}, '{8'd43, 8'd111}};
        dv = '{'{1000, 8'd3, 8'd255}, '{-5, 8'd3, 8'd0}, '{300, 8'd0, 8'd255},
               '{766, 8'd3, 8'd255}, '{765, 8'd3, 8'd255}, '{384, 8'd3, 8'd128},
               '{600, 8'd3, 8'd200}, '{192, 8'd3, 8'd64}, '{7, 8'd2, 8'd3}};
        pv = '{'{384, 8'd3, 360}, '{0, 8'd3, 0}, '{300, 8'd0, 717}, '{192, 8'd3, 180}};

        tick(2);
        chk("reset_am", int'(am), 128);
        chk("reset_wave", int'(wave), 0);

        for (int i = 0; i < 10; i++) begin
            dds_theta = {8'd64, 8'd64, sv[i].th};
            #1;
            chk($sformatf("sin_th%0d", sv[i].th), int'(dds_am[7:0]), int'(sv[i].exp_am));
            if (i == 0) begin
                chk("sin_v1", int'(dds_am[15:8]), 127);
                chk("sin_v2", int'(dds_am[23:16]), 127);
            end
        end

        am_sum = 600; den = 3;
        do_reset();
        tick(32);
        chk("div_first_pending", int'(am), 128);
        tick(1);
        chk("div_first_valid", int'(am), 200);
        am_sum = 384;
        tick(70);
        chk("div_steady", int'(am), 128);

        for (int i = 0; i < 9; i++) begin
            am_sum = dv[i].sum; den = dv[i].d;
            tick(70);
            chk($sformatf("div_%0d_by_%0d", dv[i].sum, dv[i].d), int'(am), int'(dv[i].exp_am));
        end

        for (int i = 0; i < 4; i++) begin
            am_sum = pv[i].sum; den = pv[i].d;
            tick(320);
            h = 0;
            repeat (720) begin tick(1); h += int'(wave); end
            chk($sformatf("pwm_high_%0d_by_%0d", pv[i].sum, pv[i].d), h, pv[i].exp_high);
        end

        // Reset in the middle of a RUN phase.
        am_sum = 600; den = 3;
        do_reset();
        tick(75);
        chk("pre_reset_am", int'(am), 200);
        rst = 1'b1;
        tick(1);
        chk("midrst_am", int'(am), 128);
        chk("midrst_wave", int'(wave), 0);
        rst = 1'b0;
        tick(32);
        chk("midrst_pending", int'(am), 128);
        tick(1);
        chk("midrst_valid", int'(am), 200);

        // am drops 128 -> 0 at edge 264, i.e. early in the second PWM period.
        am_sum = 384; den = 3;
        do_reset();
        h1 = 0; h2 = 0; h3 = 0;
        for (int e = 1; e <= 720; e++) begin
            tick(1);
            if (e == 231) am_sum = 0;
            if (e == 263) chk("upd_am_before", int'(am), 128);
            if (e == 264) begin
                chk("upd_am_after", int'(am), 0);
                chk("upd_wave_high", int'(wave), 1);
            end
            if (e >= 241 && e <= 480) h1 += int'(wave);
            if (e >= 266 && e <= 480) h2 += int'(wave);
            if (e >= 481) h3 += int'(wave);
        end
`ifdef DAC_SYNC_UPDATE_EN
        chk("upd_sync_period_high", h1, 120);
`else
        chk("upd_async_low_after_2", h2, 0);
`endif
        chk("upd_next_period_high", h3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
